dpd_feature_extract: RTL and testbench



---
 rtl/dpd_feature_extract_pkg.sv | 27 ++
 rtl/dpd_isqrt_serial.sv | 78 +++++++
 rtl/dpd_feature_extract.sv | 161 ++++++++++++++++
 tb/tb_dpd_feature_extract.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dpd_feature_extract_pkg.sv
// Shared constants and types for the DPD feature-extraction front end.
// Widths, feature ordering and FSM states used by the top and its square-root unit.
package dpd_feature_extract_pkg;

  localparam int DATA_W       = 14;
  localparam int FRAC         = 13;
  localparam int TAPS         = 3;
  localparam int FEAT_PER_TAP = 4;
  localparam int N_FEAT       = TAPS * FEAT_PER_TAP;
  localparam int M2_W         = 2 * DATA_W;

  localparam int FEAT_I    = 0;
  localparam int FEAT_Q    = 1;
  localparam int FEAT_ABS  = 2;
  localparam int FEAT_ABS3 = 3;

  localparam logic [DATA_W-1:0] SAT_MAX = 14'd8191;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAG2,
    ST_SQRT,
    ST_CUBE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/dpd_isqrt_serial.sv
// Bit-serial non-restoring floor square root: RAD_W = 2*ROOT_W radicand in,
// one root bit per cycle MSB first; done pulses during the last iteration cycle.
module dpd_isqrt_serial #(
  parameter int ROOT_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic                  done,
  output logic [ROOT_W-1:0]     root
);

  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 3;
  localparam int CNT_W = $clog2(ROOT_W);

  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RAD_W-1:0]        rad_q, rad_d;
  logic signed [REM_W-1:0] rem_q, rem_d;
  logic [ROOT_W-1:0]       root_q, root_d;

  logic signed [REM_W-1:0] rem_shift;
  logic signed [REM_W-1:0] rem_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
    end
  end

  // The partial remainder may go negative; its sign selects subtract or add
  // on the next step and directly gives the root bit, so no restore is needed.
  always_comb begin
    rem_shift = (rem_q <<< 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    if (!rem_q[REM_W-1])
      rem_new = rem_shift - REM_W'({root_q, 2'b01});
    else
      rem_new = rem_shift + REM_W'({root_q, 2'b11});
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(ROOT_W - 1);
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
    end else if (busy_q) begin
      rem_d  = rem_new;
      root_d = {root_q[ROOT_W-2:0], ~rem_new[REM_W-1]};
      rad_d  = rad_q << 2;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0)
        busy_d = 1'b0;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign root = root_q;

endmodule

// File: rtl/dpd_feature_extract.sv
// Streaming |x| / |x|^3 feature extractor: accepts one complex Q1.13 sample,
// keeps a 3-tap history and presents a 12-element Q.13 feature vector.
module dpd_feature_extract
  import dpd_feature_extract_pkg::*;
#(
  parameter int DATA_W       = dpd_feature_extract_pkg::DATA_W,
  parameter int TAPS         = dpd_feature_extract_pkg::TAPS,
  parameter int FEAT_PER_TAP = dpd_feature_extract_pkg::FEAT_PER_TAP,
  parameter int FRAC         = dpd_feature_extract_pkg::FRAC
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [DATA_W-1:0]              in_i,
  input  logic signed [DATA_W-1:0]              in_q,
  input  logic                                  hist_clear,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [TAPS*FEAT_PER_TAP*DATA_W-1:0]   out_feat
);

  localparam int NF     = TAPS * FEAT_PER_TAP;
  localparam int SQ_W   = 2 * DATA_W;
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam logic [DATA_W-1:0] SAT = DATA_W'((1 << (DATA_W - 1)) - 1);

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] i_q, i_d;
  logic signed [DATA_W-1:0] q_q, q_d;
  logic [SQ_W-1:0]          m2_q, m2_d;
  logic [DATA_W-1:0]        tap_q [TAPS][FEAT_PER_TAP];
  logic [DATA_W-1:0]        tap_d [TAPS][FEAT_PER_TAP];
  logic [NF*DATA_W-1:0]     out_feat_q, out_feat_d;
  logic [NF*DATA_W-1:0]     tap_pack;

  logic                     sqrt_start;
  logic                     sqrt_done;
  logic [DATA_W-1:0]        sqrt_root;

  logic signed [SQ_W-1:0]   i_ext, q_ext, sq_i, sq_q;
  logic [SQ_W-1:0]          m2_calc;
  logic [DATA_W:0]          m2q;
  logic [PROD_W-1:0]        prod;
  logic [DATA_W+1:0]        cube_raw;
  logic [DATA_W-1:0]        mag_sat, cube_sat;

  // -8192^2 + -8192^2 = 2^27 wraps the signed sum but is exact as unsigned.
  assign i_ext   = SQ_W'(i_q);
  assign q_ext   = SQ_W'(q_q);
  assign sq_i    = i_ext * i_ext;
  assign sq_q    = q_ext * q_ext;
  assign m2_calc = $unsigned(sq_i) + $unsigned(sq_q);

  assign m2q      = (DATA_W + 1)'(m2_q >> FRAC);
  assign prod     = PROD_W'(sqrt_root) * PROD_W'(m2q);
  assign cube_raw = (DATA_W + 2)'(prod >> FRAC);
  assign mag_sat  = (sqrt_root > SAT) ? SAT : sqrt_root;
  assign cube_sat = (cube_raw > (DATA_W + 2)'(SAT)) ? SAT : cube_raw[DATA_W-1:0];

  dpd_isqrt_serial #(
    .ROOT_W (DATA_W)
  ) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand (m2_calc),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_MAG2;
      ST_MAG2:                state_d = ST_SQRT;
      ST_SQRT: if (sqrt_done) state_d = ST_CUBE;
      ST_CUBE:                state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_HOLD);
    sqrt_start = (state_q == ST_MAG2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q        <= '0;
      q_q        <= '0;
      m2_q       <= '0;
      out_feat_q <= '0;
      for (int t = 0; t < TAPS; t++)
        for (int f = 0; f < FEAT_PER_TAP; f++)
          tap_q[t][f] <= '0;
    end else begin
      i_q        <= i_d;
      q_q        <= q_d;
      m2_q       <= m2_d;
      out_feat_q <= out_feat_d;
      tap_q      <= tap_d;
    end
  end

  // A clear in IDLE is applied before a same-cycle sample is latched.
  always_comb begin
    i_d   = i_q;
    q_d   = q_q;
    m2_d  = m2_q;
    tap_d = tap_q;
    case (state_q)
      ST_IDLE: begin
        if (hist_clear)
          for (int t = 0; t < TAPS; t++)
            for (int f = 0; f < FEAT_PER_TAP; f++)
              tap_d[t][f] = '0;
        if (in_valid) begin
          i_d = in_i;
          q_d = in_q;
        end
      end
      ST_MAG2: m2_d = m2_calc;
      ST_CUBE: begin
        for (int t = TAPS - 1; t > 0; t--)
          tap_d[t] = tap_q[t-1];
        tap_d[0][FEAT_I]    = i_q;
        tap_d[0][FEAT_Q]    = q_q;
        tap_d[0][FEAT_ABS]  = mag_sat;
        tap_d[0][FEAT_ABS3] = cube_sat;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NF; gi++) begin : g_pack
      assign tap_pack[gi*DATA_W +: DATA_W] = tap_d[gi / FEAT_PER_TAP][gi % FEAT_PER_TAP];
    end
  endgenerate

  always_comb begin
    out_feat_d = out_feat_q;
    if (state_q == ST_CUBE)
      out_feat_d = tap_pack;
  end

  assign out_feat = out_feat_q;

endmodule

// File: tb/tb_dpd_feature_extract.sv
// Self-checking bench for dpd_feature_extract: directed and random samples
// compared against an integer-arithmetic model of the feature history.
module tb_dpd_feature_extract;

  localparam int W  = 14;
  localparam int VW = 168;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_i;
  logic signed [W-1:0]  in_q;
  logic                 hist_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [VW-1:0]        out_feat;

  int total = 0;
  int bad   = 0;

  int mi [3];
  int mq [3];
  int mm [3];
  int mc [3];

  dpd_feature_extract dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_i       (in_i),
    .in_q       (in_q),
    .hist_clear (hist_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_feat   (out_feat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int isqrt_ref(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 1 << 15;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return int'(lo);
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 3; t++) begin
      mi[t] = 0; mq[t] = 0; mm[t] = 0; mc[t] = 0;
    end
  endtask

  task automatic model_push(input int si, input int sq);
    longint m2, c;
    int r;
    m2 = longint'(si) * si + longint'(sq) * sq;
    r  = isqrt_ref(m2);
    c  = (longint'(r) * (m2 / 8192)) / 8192;
    for (int t = 2; t > 0; t--) begin
      mi[t] = mi[t-1]; mq[t] = mq[t-1]; mm[t] = mm[t-1]; mc[t] = mc[t-1];
    end
    mi[0] = si;
    mq[0] = sq;
    mm[0] = (r > 8191) ? 8191 : r;
    mc[0] = (c > 8191) ? 8191 : int'(c);
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int t = 0; t < 3; t++) begin
      v[(t*4+0)*W +: W] = W'(mi[t]);
      v[(t*4+1)*W +: W] = W'(mq[t]);
      v[(t*4+2)*W +: W] = W'(mm[t]);
      v[(t*4+3)*W +: W] = W'(mc[t]);
    end
    return v;
  endfunction

  // mode: 0 plain, 1 hist_clear pulsed during SQRT, 2 hist_clear with the sample
  task automatic send(input int si, input int sq, input int mode, input int hold);
    int n;
    check("in_ready_idle", VW'(in_ready), VW'(1));
    in_valid = 1'b1;
    in_i     = W'(si);
    in_q     = W'(sq);
    if (mode == 2) begin
      hist_clear = 1'b1;
      model_clear();
    end
    model_push(si, sq);
    @(negedge clk);
    in_valid   = 1'b0;
    hist_clear = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (n == 8) check("in_ready_busy", VW'(in_ready), VW'(0));
      in_i = W'($urandom);
      in_q = W'($urandom);
      if (mode == 1) hist_clear = (n >= 4 && n < 12);
      @(negedge clk);
      n++;
    end
    hist_clear = 1'b0;
    check("latency", VW'(n), VW'(17));
    check("feat", out_feat, exp_vec());
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_feat", out_feat, exp_vec());
        check("hold_ready", VW'(in_ready), VW'(0));
        check("hold_valid", VW'(out_valid), VW'(1));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", VW'(out_valid), VW'(0));
    $display("sample I=%0d Q=%0d mode=%0d hold=%0d latency=%0d feat=%h", si, sq, mode, hold, n, out_feat);
  endtask

  initial begin
    int seen;
    logic signed [W-1:0] ri, rq;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_i       = '0;
    in_q       = '0;
    hist_clear = 1'b0;
    out_ready  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", VW'(in_ready), VW'(1));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_feat", out_feat, '0);

    // Abort during SQRT with an asynchronous reset; no vector may appear.
    in_valid = 1'b1;
    in_i     = W'(4000);
    in_q     = W'(-1234);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("midrst_in_ready", VW'(in_ready), VW'(1));
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_valid", VW'(seen), VW'(0));
    check("midrst_out_feat", out_feat, '0);
    $display("reset mid-SQRT: out_valid pulses=%0d out_feat=%h", seen, out_feat);

    send(4096, 0, 0, 0);
    check("s1_tap0", VW'(out_feat[55:0]), VW'({14'd1024, 14'd4096, 14'd0, 14'd4096}));
    check("s1_tap12_zero", VW'(out_feat[167:56]), '0);

    send(3072, 4096, 0, 0);
    check("s2_tap0", VW'(out_feat[55:0]), VW'({14'd2000, 14'd5120, 14'd4096, 14'd3072}));
    check("s2_tap1", VW'(out_feat[111:56]), VW'({14'd1024, 14'd4096, 14'd0, 14'd4096}));

    send(-8192, -8192, 0, 0);
    check("s3_tap0", VW'(out_feat[55:0]), VW'({14'd8191, 14'd8191, 14'h2000, 14'h2000}));

    ri = W'($urandom);
    rq = W'($urandom);
    send(int'(ri), int'(rq), 0, 20);
    check("s4_tap2", VW'(out_feat[167:112]), VW'({14'd2000, 14'd5120, 14'd4096, 14'd3072}));

    hist_clear = 1'b1;
    model_clear();
    @(negedge clk);
    hist_clear = 1'b0;
    send(4096, 0, 0, 0);
    check("clr_tap12_zero", VW'(out_feat[167:56]), '0);

    ri = W'($urandom);
    rq = W'($urandom);
    send(int'(ri), int'(rq), 1, 0);
    check("clr_sqrt_ignored", VW'(out_feat[111:56]), VW'({14'd1024, 14'd4096, 14'd0, 14'd4096}));

    for (int k = 0; k < 8; k++) begin
      ri = W'($urandom);
      rq = W'($urandom);
      send(int'(ri), int'(rq), (k == 5) ? 2 : 0, (k == 3) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
